// File: rtl/phase_seq.sv
// rtl/phase_seq.sv - parametrised one-hot pipeline phase sequencer with stall, skip, halt/resume and retire.
// Optional retire counter enabled by macro PHASE_SEQ_RETIRE_CNT_EN.
module phase_seq #(
  parameter int NPH   = 5,
  parameter int SYNC  = 3,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             hlt,
  input  logic             stall,
  input  logic [NPH-1:0]   skip,
  input  logic             resume,
  output logic [NPH-1:0]   phase,
  output logic             running,
  output logic             halted,
  output logic             retire,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [NPH-1:0] ONE = {{(NPH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t           state, state_nxt;
  logic [SYNC-1:0]  sync;
  logic [NPH-1:0]   skip_q, skip_q_nxt, phase_nxt;
  logic [NPH-1:0]   mask, above, cand, step;
  logic             retire_nxt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) sync <= '0;
    else        sync <= {sync[SYNC-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sync[SYNC-1]) state_nxt = RUN;
      RUN:     if (hlt) state_nxt = HALTED;
      HALTED:  if (resume && !hlt) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Leaving phase[0] uses the freshly presented skip mask so it governs this instruction.
  always_comb begin
    mask     = phase[0] ? (skip & ~ONE) : skip_q;
    above[0] = 1'b0;
    for (int j = 1; j < NPH; j++) above[j] = above[j-1] | phase[j-1];
    cand = above & ~mask;
    step = cand & (~cand + ONE);
  end

  always_comb begin
    phase_nxt  = phase;
    skip_q_nxt = skip_q;
    retire_nxt = 1'b0;
    case (state)
      IDLE: if (sync[SYNC-1]) phase_nxt = ONE;
      RUN: begin
        if (hlt) begin
          phase_nxt = '0;
        end else if (!stall) begin
          if (phase[0]) skip_q_nxt = mask;
          if (|step) begin
            phase_nxt = step;
          end else begin
            phase_nxt  = ONE;
            retire_nxt = 1'b1;
          end
        end
      end
      HALTED:  phase_nxt = (resume && !hlt) ? ONE : '0;
      default: phase_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase  <= '0;
      skip_q <= '0;
      retire <= 1'b0;
    end else begin
      phase  <= phase_nxt;
      skip_q <= skip_q_nxt;
      retire <= retire_nxt;
    end
  end

  assign running = (state == RUN);
  assign halted  = (state == HALTED);

`ifdef PHASE_SEQ_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)          retire_cnt <= '0;
    else if (retire_nxt) retire_cnt <= retire_cnt + 1'b1;
  end
`else
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_phase_seq.sv
// tb/tb_phase_seq.sv - table-driven scoreboard bench for phase_seq (NPH=5, SYNC=3, CNT_W=2).
module tb_phase_seq;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       hlt = 1'b0, stall = 1'b0, resume = 1'b0;
  logic [4:0] skip = '0;
  logic [4:0] phase;
  logic       running, halted, retire;
  logic [1:0] retire_cnt;

  phase_seq #(.NPH(5), .SYNC(3), .CNT_W(2)) dut (
    .clk(clk), .n_rst(n_rst), .hlt(hlt), .stall(stall), .skip(skip), .resume(resume),
    .phase(phase), .running(running), .halted(halted), .retire(retire), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       h, s, r;
    logic [4:0] sk;
    logic [4:0] ph;
    logic       run, hal, ret;
    logic [1:0] cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic h, logic s, logic r, logic [4:0] sk,
                              logic [4:0] ph, logic run, logic hal, logic ret, logic [1:0] cnt);
    vec_t v;
    v.h = h; v.s = s; v.r = r; v.sk = sk;
    v.ph = ph; v.run = run; v.hal = hal; v.ret = ret; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name);
    vec_t       e;
    logic [1:0] ecnt;
    logic [9:0] act, expv;
    e = exp_q.pop_front();
`ifdef PHASE_SEQ_RETIRE_CNT_EN
    ecnt = e.cnt;
`else
    ecnt = 2'd0;
`endif
    act  = {phase, running, halted, retire, retire_cnt};
    expv = {e.ph, e.run, e.hal, e.ret, ecnt};
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got phase=%b run=%b hlt=%b ret=%b cnt=%0d, want phase=%b run=%b hlt=%b ret=%b cnt=%0d",
               name, phase, running, halted, retire, retire_cnt, e.ph, e.run, e.hal, e.ret, ecnt);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    hlt = v.h; stall = v.s; resume = v.r; skip = v.sk;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // inputs: hlt stall resume skip | expected after edge: phase running halted retire cnt
    tbl.push_back(mk(0,0,0,5'b00000, 5'b00000,0,0,0,0));
    tbl.push_back(mk(1,1,1,5'b00000, 5'b00000,0,0,0,0));
    tbl.push_back(mk(0,0,0,5'b00000, 5'b00000,0,0,0,0));
    tbl.push_back(mk(1,1,1,5'b00000, 5'b00001,1,0,0,0));
    tbl.push_back(mk(0,0,0,5'b00000, 5'b00010,1,0,0,0));
    tbl.push_back(mk(0,0,0,5'b00000, 5'b00100,1,0,0,0));
    tbl.push_back(mk(0,0,0,5'b00000, 5'b01000,1,0,0,0));
    tbl.push_back(mk(0,0,0,5'b00000, 5'b10000,1,0,0,0));
    tbl.push_back(mk(0,0,0,5'b00000, 5'b00001,1,0,1,1));
    tbl.push_back(mk(0,0,0,5'b01000, 5'b00010,1,0,0,1));
    tbl.push_back(mk(0,0,0,5'b00000, 5'b00100,1,0,0,1));
    tbl.push_back(mk(0,0,0,5'b00000, 5'b10000,1,0,0,1));
    tbl.push_back(mk(0,0,0,5'b00000, 5'b00001,1,0,1,2));
    tbl.push_back(mk(0,0,0,5'b00000, 5'b00010,1,0,0,2));
    tbl.push_back(mk(0,0,0,5'b00000, 5'b00100,1,0,0,2));
    tbl.push_back(mk(0,0,0,5'b00000, 5'b01000,1,0,0,2));
    tbl.push_back(mk(0,0,0,5'b00000, 5'b10000,1,0,0,2));
    tbl.push_back(mk(0,0,0,5'b00000, 5'b00001,1,0,1,3));
    tbl.push_back(mk(0,0,0,5'b00000, 5'b00010,1,0,0,3));
    tbl.push_back(mk(0,0,0,5'b00000, 5'b00100,1,0,0,3));
    tbl.push_back(mk(0,1,0,5'b00000, 5'b00100,1,0,0,3));
    tbl.push_back(mk(0,1,0,5'b00000, 5'b00100,1,0,0,3));
    tbl.push_back(mk(0,1,0,5'b00000, 5'b00100,1,0,0,3));
    tbl.push_back(mk(0,0,0,5'b00000, 5'b01000,1,0,0,3));
    tbl.push_back(mk(1,1,0,5'b00000, 5'b00000,0,1,0,3));
    tbl.push_back(mk(1,0,1,5'b00000, 5'b00000,0,1,0,3));
    tbl.push_back(mk(0,0,1,5'b00000, 5'b00001,1,0,0,3));
    tbl.push_back(mk(0,1,0,5'b11110, 5'b00001,1,0,0,3));
    tbl.push_back(mk(0,0,0,5'b11110, 5'b00001,1,0,1,0));
    tbl.push_back(mk(0,0,0,5'b11110, 5'b00001,1,0,1,1));
    tbl.push_back(mk(0,0,0,5'b11110, 5'b00001,1,0,1,2));
    tbl.push_back(mk(0,0,0,5'b11110, 5'b00001,1,0,1,3));
    tbl.push_back(mk(0,0,0,5'b11110, 5'b00001,1,0,1,0));
    tbl.push_back(mk(0,0,0,5'b00000, 5'b00010,1,0,0,0));
    tbl.push_back(mk(0,0,0,5'b00000, 5'b00100,1,0,0,0));
    tbl.push_back(mk(0,0,0,5'b00000, 5'b01000,1,0,0,0));
    tbl.push_back(mk(0,0,0,5'b00000, 5'b10000,1,0,0,0));
    tbl.push_back(mk(1,0,0,5'b00000, 5'b00000,0,1,0,0));
    tbl.push_back(mk(0,0,1,5'b00000, 5'b00001,1,0,0,0));
    tbl.push_back(mk(0,0,0,5'b00000, 5'b00010,1,0,0,0));
    tbl.push_back(mk(0,0,0,5'b00000, 5'b00100,1,0,0,0));

    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(mk(0,0,0,5'b0, 5'b00000,0,0,0,0));
    check("reset_state");
    n_rst = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset mid-instruction, then the full start delay again.
    #2;
    n_rst = 1'b0;
    #1;
    exp_q.push_back(mk(0,0,0,5'b0, 5'b00000,0,0,0,0));
    check("async_reset_now");
    run_vec(mk(0,0,0,5'b0, 5'b00000,0,0,0,0), "reset_held");
    n_rst = 1'b1;
    for (int k = 1; k <= 3; k++) run_vec(mk(0,0,0,5'b0, 5'b00000,0,0,0,0), $sformatf("restart_edge%0d", k));
    run_vec(mk(0,0,0,5'b0, 5'b00001,1,0,0,0), "restart_edge4");
    run_vec(mk(0,0,0,5'b0, 5'b00010,1,0,0,0), "restart_step");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/phase_seq.md
# phase_seq

Parametrised one-hot pipeline phase sequencer, the successor to the fixed five-phase generator. It drives the per-instruction phase vector (fetch, decode/read, execute, ...) for the multicycle core and adds:
- configurable phase count and reset-release delay
- stall hold and per-instruction phase skipping
- halt/resume control
- an instruction-retire pulse and counter

It sits between the top-level clock/reset and the datapath control decoders.

## Interface
- `NPH`, default 5: number of phases; one-hot width. Must be ≥2.
- `SYNC`, default 3: reset-release synchroniser depth. Must be ≥2.
- `CNT_W`, default 32: retire counter width.

- `clk`  in  1  system clock, rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `hlt`  in  1  halt request, sampled in RUN.
- `stall`  in  1  hold the current phase for this cycle.
- `skip`  in  NPH  phase skip mask for the next instruction. Bit 0 is ignored.
- `resume`  in  1  leave HALTED.
- `phase`  out  NPH  one-hot phase. All-zero when not running.
- `running`  out  1  state == RUN.
- `halted`  out  1  state == HALTED.
- `retire`  out  1  one-cycle pulse per completed instruction.
- `retire_cnt`  out  CNT_W  retired instruction count.

## Operation
- **Reset (n_rst low):**
  - All outputs 0; state IDLE.
  - `sync[SYNC-1:0]` = 0, cleared asynchronously by `n_rst`.
  - `skip_q` = 0.
- **sync:** shift register fed with constant 1. Gives a deterministic start delay after reset release.
- **IDLE:**
  - When `sync[SYNC-1]` == 1: set `phase` = 1 (bit 0) and go to RUN.
  - `hlt`, `stall`, `resume` are ignored.
- **RUN**, evaluated in priority order:
  1. `hlt` = 1: `phase` ← 0, go to HALTED. No retire, even if in the last active phase.
  2. `stall` = 1: `phase` held. `skip_q` held. No retire.
  3. Otherwise advance:
     - From `phase[i]`, go to the lowest j > i with `skip_q[j]` == 0.
     - If no such j exists, wrap to `phase[0]` and assert `retire`.
     - When advancing out of `phase[0]`, `skip` is captured into `skip_q` first (bit 0 forced 0), so the captured mask governs that same instruction.
- **HALTED:**
  - `phase` = 0, `halted` = 1.
  - `resume` = 1 and `hlt` = 0: `phase` ← 1, go to RUN. No retire.
  - `hlt` = 1 together with `resume`: remain HALTED.
- **Retire counter:**
  - Increments by 1 on every `retire` pulse.
  - Wraps modulo 2^CNT_W; no saturation.
- **Reset mid-operation:** immediate clear of all state. The full SYNC delay applies again on release.
- **Invariants:**
  - `phase` is one-hot in RUN and all-zero otherwise.
  - `running` and `halted` are never both high.

## Timing
- All outputs registered; no combinational path from any input to any output.
- **Start:** `n_rst` rises before clk edge 1. `sync` MSB is set at edge SYNC. `phase[0]` and `running` rise at edge SYNC+1.
- **Step latency:** `phase` changes 1 cycle after the deciding edge's inputs (`hlt`/`stall`/`skip`) are sampled.
- **Retire:** `retire` is high during the first cycle of `phase[0]` after a wrap. `retire_cnt` updates at that same edge.
- **Halt:** `hlt` sampled at edge k → `phase` = 0 and `halted` = 1 after edge k.
- **Resume:** `resume` sampled at edge k → `phase[0]` after edge k.
- **All-ones skip:** `phase[0]` remains high and `retire` pulses every cycle.

## Configuration
- Macro `PHASE_SEQ_RETIRE_CNT_EN`.
- **Defined:** `retire_cnt` counter implemented as above.
- **Undefined:**
  - No counter flops.
  - `retire_cnt` tied to 0.
  - `retire` pulse behaviour unchanged.

## Test plan
All scenarios use NPH = 5, SYNC = 3.
1. **Reset release:** release `n_rst`, no other inputs → `phase` = 00001 after edge 4, then 00010, 00100, 01000, 10000, 00001; `retire` = 1 on the second 00001; `retire_cnt` = 1.
2. **Skip:** `skip` = 01000 while leaving `phase[0]` → sequence 00001→00010→00100→10000→00001; next instruction with `skip` = 0 visits all 5 phases.
3. **Stall, then halt priority:** `stall` held 3 cycles in 00100 → 00100 for 4 cycles total, then advances to 01000. Then `hlt` and `stall` asserted together in 01000 → `phase` = 0, `halted` = 1, `retire_cnt` unchanged.
4. **Halt/resume:** `hlt` + `resume` together in HALTED → stays halted. `resume` alone → `phase` = 00001 next cycle, `retire` = 0.
5. **Counter wrap:** `CNT_W` = 2, `skip` = 11110 → `retire` every cycle; `retire_cnt` goes 1, 2, 3, 0. With the macro undefined, `retire_cnt` stays 0.
6. **Mid-run reset:** `n_rst` pulsed low in 00100 → all outputs 0 immediately; after release, `phase[0]` returns after edge 4 of the new sequence.
